fifo_txuart: RTL and testbench



---
 rtl/fifo_txuart.sv | 126 ++++++++++++
 tb/tb_fifo_txuart.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_txuart.sv
// rtl/fifo_txuart.sv - 8N1 UART transmitter draining a FIFO read port, with CTS flow control and break
module fifo_txuart #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_empty_n,
  input  logic [7:0] i_data,
  output logic       o_rd,
  input  logic       i_cts_n,
  input  logic       i_break,
  output logic       o_uart_tx,
  output logic       o_busy
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  localparam logic [23:0] RELOAD = CLOCKS_PER_BAUD - 24'd1;

  state_t      state, state_nx;
  logic [23:0] baud_cnt, baud_cnt_nx;
  logic [2:0]  bit_idx, bit_idx_nx;
  logic [7:0]  sreg, sreg_nx;
  logic        tx_nx;
  logic        period_end;
  logic        ready;
  logic        launch;

  assign period_end = (baud_cnt == 24'd0);
  assign ready      = (state == S_IDLE) || ((state == S_STOP) && period_end);
  // Gated by reset so no pop can be issued while the block is held in reset.
  assign launch     = i_rst_n && ready && i_empty_n && !i_cts_n && !i_break;
  assign o_rd       = launch;
  assign o_busy     = (state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      baud_cnt  <= 24'd0;
      bit_idx   <= 3'd0;
      sreg      <= 8'd0;
      o_uart_tx <= 1'b1;
    end else begin
      state     <= state_nx;
      baud_cnt  <= baud_cnt_nx;
      bit_idx   <= bit_idx_nx;
      sreg      <= sreg_nx;
      o_uart_tx <= tx_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    baud_cnt_nx = period_end ? RELOAD : (baud_cnt - 24'd1);
    bit_idx_nx  = bit_idx;
    sreg_nx     = sreg;
    tx_nx       = o_uart_tx;
    case (state)
      S_IDLE: begin
        baud_cnt_nx = 24'd0;
        tx_nx       = 1'b1;
        if (i_break) begin
          state_nx = S_BREAK;
          tx_nx    = 1'b0;
        end else if (launch) begin
          state_nx    = S_START;
          sreg_nx     = i_data;
          baud_cnt_nx = RELOAD;
          tx_nx       = 1'b0;
        end
      end
      S_START: begin
        tx_nx = 1'b0;
        if (period_end) begin
          state_nx   = S_DATA;
          bit_idx_nx = 3'd0;
          tx_nx      = sreg[0];
        end
      end
      S_DATA: begin
        if (period_end) begin
          if (bit_idx == 3'd7) begin
            state_nx = S_STOP;
            tx_nx    = 1'b1;
          end else begin
            // Line is registered from the post-shift LSB, i.e. the current bit 1.
            sreg_nx    = {1'b0, sreg[7:1]};
            bit_idx_nx = bit_idx + 3'd1;
            tx_nx      = sreg[1];
          end
        end
      end
      S_STOP: begin
        tx_nx = 1'b1;
        if (period_end) begin
          if (launch) begin
            state_nx = S_START;
            sreg_nx  = i_data;
            tx_nx    = 1'b0;
          end else if (i_break) begin
            state_nx = S_BREAK;
            tx_nx    = 1'b0;
          end else begin
            state_nx    = S_IDLE;
            baud_cnt_nx = 24'd0;
          end
        end
      end
      S_BREAK: begin
        // Counter is kept loaded so the exit stop bit is a full period.
        baud_cnt_nx = RELOAD;
        tx_nx       = 1'b0;
        if (!i_break) begin
          state_nx = S_STOP;
          tx_nx    = 1'b1;
        end
      end
      default: begin
        state_nx    = S_IDLE;
        baud_cnt_nx = 24'd0;
        tx_nx       = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_txuart.sv
// tb/tb_fifo_txuart.sv - directed self-checking bench for fifo_txuart
module tb_fifo_txuart;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CPB=4 instance with a small FIFO model
  logic [7:0] mem4 [0:63];
  int   wp4 = 0;
  int   rp4 = 0;
  int   nrd4 = 0;
  logic empty_n4, rd4, cts4, brk4, tx4, busy4;
  logic [7:0] data4;
  assign empty_n4 = (wp4 != rp4);
  assign data4 = mem4[rp4[5:0]];
  always @(posedge clk) if (rd4) begin rp4 <= rp4 + 1; nrd4 <= nrd4 + 1; end

  fifo_txuart #(.CLOCKS_PER_BAUD(24'd4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_empty_n(empty_n4), .i_data(data4), .o_rd(rd4),
    .i_cts_n(cts4), .i_break(brk4), .o_uart_tx(tx4), .o_busy(busy4)
  );

  // CPB=2 instance for the random stream
  logic [7:0] mem2 [0:63];
  int   wp2 = 0;
  int   rp2 = 0;
  int   nrd2 = 0;
  logic empty_n2, rd2, cts2, brk2, tx2, busy2;
  logic [7:0] data2;
  assign empty_n2 = (wp2 != rp2);
  assign data2 = mem2[rp2[5:0]];
  always @(posedge clk) if (rd2) begin rp2 <= rp2 + 1; nrd2 <= nrd2 + 1; end

  fifo_txuart #(.CLOCKS_PER_BAUD(24'd2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_empty_n(empty_n2), .i_data(data2), .o_rd(rd2),
    .i_cts_n(cts2), .i_break(brk2), .o_uart_tx(tx2), .o_busy(busy2)
  );

  // Reference receiver for CPB=2: one sample per cycle, bit k sampled in its first cycle
  logic [7:0] rx2 [0:63];
  int   nrx2 = 0;
  int   ferr2 = 0;
  int   ph = 0;
  logic active = 1'b0;
  logic [7:0] sh = 8'd0;
  always @(negedge clk) begin
    if (!active) begin
      if (rst_n === 1'b1 && tx2 === 1'b0) begin
        active <= 1'b1;
        ph <= 1;
      end
    end else begin
      if (ph >= 2 && ph <= 16 && (ph % 2) == 0) sh <= {tx2, sh[7:1]};
      if (ph == 18) begin
        if (tx2 !== 1'b1) ferr2 <= ferr2 + 1;
        rx2[nrx2[5:0]] <= sh;
        nrx2 <= nrx2 + 1;
      end
      if (ph == 19) active <= 1'b0;
      ph <= ph + 1;
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push4(input logic [7:0] b);
    mem4[wp4[5:0]] = b;
    wp4++;
  endtask

  // Called in the cycle where o_rd fired; checks the following 40 cycles of the frame.
  task automatic frame4(input logic [7:0] b, input logic next_rd, input int cts_at, input int brk_at);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      chk("frame_tx", {7'd0, tx4}, {7'd0, fr[(i - 1) / 4]});
      chk("frame_busy", {7'd0, busy4}, 8'd1);
      chk("frame_rd", {7'd0, rd4}, {7'd0, (i == 40) ? next_rd : 1'b0});
      if (i == cts_at) cts4 = 1'b1;
      if (i == brk_at) brk4 = 1'b1;
    end
  endtask

  int n0;
  int budget;

  initial begin
    cts4 = 1'b0; brk4 = 1'b0;
    cts2 = 1'b0; brk2 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_tx", {7'd0, tx4}, 8'd1);
    chk("reset_busy", {7'd0, busy4}, 8'd0);
    chk("reset_rd", {7'd0, rd4}, 8'd0);

    // single byte 0xA5
    n0 = nrd4;
    push4(8'hA5);
    #1 chk("a5_rd", {7'd0, rd4}, 8'd1);
    frame4(8'hA5, 1'b0, -1, -1);
    @(negedge clk);
    chk("a5_busy_fall", {7'd0, busy4}, 8'd0);
    chk("a5_idle_tx", {7'd0, tx4}, 8'd1);
    chk("a5_rd_count", nrd4[7:0] - n0[7:0], 8'd1);

    // back-to-back 0x00, 0xFF, 0x55
    push4(8'h00); push4(8'hFF); push4(8'h55);
    #1 chk("b2b_rd", {7'd0, rd4}, 8'd1);
    frame4(8'h00, 1'b1, -1, -1);
    frame4(8'hFF, 1'b1, -1, -1);
    frame4(8'h55, 1'b0, -1, -1);
    @(negedge clk);
    chk("b2b_busy_fall", {7'd0, busy4}, 8'd0);

    // CTS hold-off, release, and mid-frame raise
    cts4 = 1'b1;
    push4(8'h96);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("cts_hold_rd", {7'd0, rd4}, 8'd0);
      chk("cts_hold_tx", {7'd0, tx4}, 8'd1);
    end
    cts4 = 1'b0;
    #1 chk("cts_release_rd", {7'd0, rd4}, 8'd1);
    push4(8'h11);
    frame4(8'h96, 1'b0, 18, -1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("cts_after_rd", {7'd0, rd4}, 8'd0);
      chk("cts_after_tx", {7'd0, tx4}, 8'd1);
    end
    cts4 = 1'b0;
    #1 chk("cts_second_rd", {7'd0, rd4}, 8'd1);
    frame4(8'h11, 1'b0, -1, -1);

    // break during bit 5 of 0x3C
    push4(8'h3C);
    #1 chk("brk_rd", {7'd0, rd4}, 8'd1);
    push4(8'h81);
    frame4(8'h3C, 1'b0, -1, 26);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("brk_low_tx", {7'd0, tx4}, 8'd0);
      chk("brk_low_rd", {7'd0, rd4}, 8'd0);
      chk("brk_busy", {7'd0, busy4}, 8'd1);
    end
    brk4 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("brk_stop_tx", {7'd0, tx4}, 8'd1);
      chk("brk_stop_rd", {7'd0, rd4}, {7'd0, i == 4});
    end
    frame4(8'h81, 1'b0, -1, -1);

    // asynchronous reset mid-DATA
    push4(8'hC3);
    #1 chk("rst_first_rd", {7'd0, rd4}, 8'd1);
    push4(8'h5A);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_tx", {7'd0, tx4}, 8'd1);
    chk("rst_async_busy", {7'd0, busy4}, 8'd0);
    chk("rst_async_rd", {7'd0, rd4}, 8'd0);
    @(negedge clk);
    chk("rst_hold_rd", {7'd0, rd4}, 8'd0);
    rst_n = 1'b1;
    #1 chk("rst_release_rd", {7'd0, rd4}, 8'd1);
    frame4(8'h5A, 1'b0, -1, -1);

    // CPB=2 random stream with CTS toggling
    for (int i = 0; i < 50; i++) mem2[i] = 8'($urandom_range(0, 255));
    wp2 = 50;
    budget = 0;
    while (nrx2 < 50 && budget < 8000) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) cts2 = ~cts2;
      budget++;
    end
    cts2 = 1'b0;
    chk("rand_timeout", {7'd0, budget >= 8000}, 8'd0);
    repeat (30) @(negedge clk);
    chk("rand_rx_count", nrx2[7:0], 8'd50);
    chk("rand_rd_count", nrd2[7:0], nrx2[7:0]);
    chk("rand_framing", ferr2[7:0], 8'd0);
    for (int i = 0; i < 50; i++) chk("rand_byte", rx2[i], mem2[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
